// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes and the
// datapath mux / ALU control codes consumed by the datapath and ALU decoder.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_ALU   = 2'd1;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] A_PC   = 2'd0;
    localparam logic [1:0] A_RS1  = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_CMP   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL) ||
               (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/exec/
// memory/writeback, handshakes with imem/dmem and counts retired instructions.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // Handshake: a request (imem_req / dmem_req) is held high and stable until
    // its ready is sampled high at a rising edge; ready seen while the request
    // is low is ignored, and ready in the request's first cycle completes it.

    state_e state;
    state_e state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Outputs are gated by rst so a reset mid-access drops requests at once.
    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        alu_src_a = A_PC;
        alu_src_b = B_RS2;
        alu_op    = ALU_ADD;
        retire    = 1'b0;
        illegal   = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        pc_src   = PC_SRC_PLUS4;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute PC + imm as the branch/JAL target.
                    alu_src_a = A_PC;
                    alu_src_b = B_IMM;
                    alu_op    = ALU_ADD;
                    state_nx  = op_legal(opcode) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_RS2;
                            alu_op    = ALU_FUNCT;
                            state_nx  = S_WB_ALU;
                        end
                        OP_IMM: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_IMM;
                            alu_op    = ALU_FUNCT;
                            state_nx  = S_WB_ALU;
                        end
                        OP_LOAD: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_IMM;
                            alu_op    = ALU_ADD;
                            state_nx  = S_MEM_RD;
                        end
                        OP_STORE: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_IMM;
                            alu_op    = ALU_ADD;
                            state_nx  = S_MEM_WR;
                        end
                        OP_LUI: begin
                            alu_src_a = A_ZERO;
                            alu_src_b = B_IMM;
                            alu_op    = ALU_ADD;
                            state_nx  = S_WB_ALU;
                        end
                        OP_BRANCH: begin
                            alu_op   = ALU_CMP;
                            pc_we    = branch_taken;
                            pc_src   = PC_SRC_ALU;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_we    = 1'b1;
                            pc_src   = PC_SRC_ALU;
                            rf_we    = 1'b1;
                            wb_sel   = WB_SEL_PC4;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        default: state_nx = S_TRAP;
                    endcase
                end
                S_MEM_RD: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        state_nx = S_WB_MEM;
                    end
                end
                S_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (dmem_ready) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                end
                S_WB_ALU: begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_SEL_ALU;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_WB_MEM: begin
                    rf_we    = 1'b1;
                    wb_sel   = WB_SEL_MEM;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: state_nx = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle output vectors for each
// instruction class, handshake waits, reset abort, trap and counter wrap.
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .retire       (retire),
        .illegal      (illegal),
        .instret      (instret)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [17:0] outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we,
                        wb_sel, alu_src_a, alu_src_b, alu_op, retire, illegal};

    function automatic logic [17:0] ov(input logic ireq, input logic dreq,
                                       input logic dwe, input logic irw,
                                       input logic pcw, input logic [1:0] pcs,
                                       input logic rfw, input logic [1:0] wbs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic ret,
                                       input logic ill);
        return {ireq, dreq, dwe, irw, pcw, pcs, rfw, wbs, a, b, op, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, then
    // advances one clock and returns at the next falling edge.
    task automatic step_chk(input string tag, input state_e s, input logic [17:0] e);
        #1;
        check({tag, ".state"}, 32'(dut.state), 32'(s));
        check({tag, ".outs"}, 32'(outs), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction with imem always ready and dmem ready after dwait
    // stall cycles; returns the cycle count up to and including retire.
    task automatic run_count(input logic [6:0] op, input int dwait, output int n);
        int  w;
        bit  done;
        w    = 0;
        n    = 0;
        done = 1'b0;
        opcode     = op;
        imem_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            dmem_ready = dmem_req && (w == dwait);
            #1;
            n++;
            if (dmem_req) w++;
            if (retire) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        check("retire_seen", 32'(done), 32'd1);
    endtask

    localparam logic [17:0] DEC_O   = 18'(ov(0,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_IMM,ALU_ADD,0,0));
    localparam logic [17:0] FWAIT_O = 18'(ov(1,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));
    localparam logic [17:0] FRDY_O  = 18'(ov(1,0,0,1,1,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));

    typedef struct {
        logic [6:0] op;
        int         dwait;
        int         cycles;
    } cpi_t;

    cpi_t cpi_tab[9] = '{
        '{OP_R,      0, 4},
        '{OP_IMM,    0, 4},
        '{OP_LUI,    0, 4},
        '{OP_STORE,  0, 4},
        '{OP_LOAD,   0, 5},
        '{OP_LOAD,   3, 8},
        '{OP_STORE,  2, 6},
        '{OP_JAL,    0, 3},
        '{OP_BRANCH, 0, 3}
    };

    initial begin
        int          n;
        logic [31:0] cnt;

        rst          = 1'b1;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b0;

        // outputs read 0 while rst is high, even with imem_ready asserted
        repeat (2) @(negedge clk);
        #1;
        check("rst.outs", 32'(outs), 32'd0);
        check("rst.instret", instret, 32'd0);
        check("rst.state", 32'(dut.state), 32'(S_FETCH));
        @(negedge clk);
        rst = 1'b0;

        // R-type 0x00B50533, zero-wait fetch; stray dmem_ready is ignored
        opcode = 7'h33;
        step_chk("r_fetch", S_FETCH, FRDY_O);
        dmem_ready = 1'b1;
        step_chk("r_dec", S_DECODE, DEC_O);
        step_chk("r_exec", S_EXEC, ov(0,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_RS1,B_RS2,ALU_FUNCT,0,0));
        dmem_ready = 1'b0;
        step_chk("r_wb", S_WB_ALU, ov(0,0,0,0,0,PC_SRC_PLUS4,1,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,1,0));
        check("r.instret", instret, 32'd1);

        // fetch waits, then LOAD 0x0002A303 with dmem_ready late by 3 cycles
        imem_ready = 1'b0;
        opcode     = 7'h03;
        step_chk("f_wait0", S_FETCH, FWAIT_O);
        step_chk("f_wait1", S_FETCH, FWAIT_O);
        imem_ready = 1'b1;
        step_chk("ld_fetch", S_FETCH, FRDY_O);
        step_chk("ld_dec", S_DECODE, DEC_O);
        step_chk("ld_exec", S_EXEC, ov(0,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_RS1,B_IMM,ALU_ADD,0,0));
        for (int i = 0; i < 3; i++) begin
            step_chk("ld_memw", S_MEM_RD, ov(0,1,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));
        end
        dmem_ready = 1'b1;
        step_chk("ld_memr", S_MEM_RD, ov(0,1,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));
        dmem_ready = 1'b0;
        step_chk("ld_wb", S_WB_MEM, ov(0,0,0,0,0,PC_SRC_PLUS4,1,WB_SEL_MEM,A_PC,B_RS2,ALU_ADD,1,0));
        check("ld.instret", instret, 32'd2);

        // BRANCH taken then not taken
        opcode       = OP_BRANCH;
        branch_taken = 1'b1;
        step_chk("bt_fetch", S_FETCH, FRDY_O);
        step_chk("bt_dec", S_DECODE, DEC_O);
        step_chk("bt_exec", S_EXEC, ov(0,0,0,0,1,PC_SRC_ALU,0,WB_SEL_ALU,A_PC,B_RS2,ALU_CMP,1,0));
        branch_taken = 1'b0;
        step_chk("bn_fetch", S_FETCH, FRDY_O);
        step_chk("bn_dec", S_DECODE, DEC_O);
        step_chk("bn_exec", S_EXEC, ov(0,0,0,0,0,PC_SRC_ALU,0,WB_SEL_ALU,A_PC,B_RS2,ALU_CMP,1,0));
        check("br.instret", instret, 32'd4);

        // cycles-per-instruction table
        foreach (cpi_tab[k]) begin
            cnt = instret;
            run_count(cpi_tab[k].op, cpi_tab[k].dwait, n);
            check($sformatf("cpi_op%02h_w%0d", cpi_tab[k].op, cpi_tab[k].dwait),
                  32'(n), 32'(cpi_tab[k].cycles));
            check("cpi_instret_inc", instret, cnt + 32'd1);
        end

        // reset in the middle of a stalled store
        opcode = OP_STORE;
        step_chk("st_fetch", S_FETCH, FRDY_O);
        step_chk("st_dec", S_DECODE, DEC_O);
        step_chk("st_exec", S_EXEC, ov(0,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_RS1,B_IMM,ALU_ADD,0,0));
        step_chk("st_mem0", S_MEM_WR, ov(0,1,1,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));
        step_chk("st_mem1", S_MEM_WR, ov(0,1,1,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,0));
        #2;
        rst = 1'b1;
        #1;
        check("st_rst.outs", 32'(outs), 32'd0);
        check("st_rst.instret", instret, 32'd0);
        @(negedge clk);
        #1;
        check("st_rst_hold.outs", 32'(outs), 32'd0);
        check("st_rst_hold.state", 32'(dut.state), 32'(S_FETCH));
        rst        = 1'b0;
        imem_ready = 1'b0;
        step_chk("st_resume", S_FETCH, FWAIT_O);

        // counter wrap: preload all-ones while idling in FETCH, then a JAL
        force dut.instret = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.instret;
        #1;
        check("wrap.preload", instret, 32'hFFFF_FFFF);
        opcode     = OP_JAL;
        imem_ready = 1'b1;
        step_chk("jal_fetch", S_FETCH, FRDY_O);
        step_chk("jal_dec", S_DECODE, DEC_O);
        step_chk("jal_exec", S_EXEC, ov(0,0,0,0,1,PC_SRC_ALU,1,WB_SEL_PC4,A_PC,B_RS2,ALU_ADD,1,0));
        check("wrap.instret", instret, 32'd0);

        // illegal opcode traps after DECODE and stays until reset
        opcode = 7'h7F;
        step_chk("ill_fetch", S_FETCH, FRDY_O);
        dmem_ready = 1'b1;
        step_chk("ill_dec", S_DECODE, DEC_O);
        for (int i = 0; i < 20; i++) begin
            step_chk("trap", S_TRAP, ov(0,0,0,0,0,PC_SRC_PLUS4,0,WB_SEL_ALU,A_PC,B_RS2,ALU_ADD,0,1));
        end
        dmem_ready = 1'b0;
        check("trap.instret", instret, 32'd0);
        rst = 1'b1;
        #1;
        check("trap_rst.outs", 32'(outs), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ready = 1'b0;
        step_chk("trap_resume", S_FETCH, FWAIT_O);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
